// File: rtl/mul8u_share_arb.sv
`default_nettype none
// ============================================================================
// mul8u_share_arb : round-robin time-sharing of one 8x8 unsigned multiplier
// Revision        : 1.0
// ============================================================================
module mul8u_share_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic [15:0]          mul_o,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_prod,
    output logic                 busy,
    output logic [15:0]          ops_done
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_CALC    = 2'd1;
    localparam logic [1:0]  c_RESP    = 2'd2;
    localparam logic [15:0] c_OPS_MAX = 16'hFFFF;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [ID_W-1:0] r_last;
    logic [ID_W-1:0] r_cur_id;
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;
    logic            w_found;
    logic            w_slot;
    logic            w_grant;
    logic [7:0]      w_sel_a;
    logic [7:0]      w_sel_b;

    // Round-robin scan starting just after the previous winner.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_sum = {1'b0, r_last} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            end
            if (!w_found && req_valid[w_sum[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_slot  = !rst && ((r_state == c_IDLE) || ((r_state == c_RESP) && rsp_ready));
    assign w_grant = w_slot && w_found;
    assign w_sel_a = req_a[{w_idx, 3'b000} +: 8];
    assign w_sel_b = req_b[{w_idx, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  w_state_nxt = w_grant ? c_CALC : c_IDLE;
            c_CALC:  w_state_nxt = c_RESP;
            c_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = w_grant ? c_CALC : c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_idx] = 1'b1;
        end
        rsp_valid = (r_state == c_RESP);
        busy      = (r_state == c_CALC) || (r_state == c_RESP);
    end

    // Operand registers only load on a grant so the multiplier inputs stay quiet otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last   <= ID_W'(N_REQ - 1);
            r_cur_id <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            rsp_id   <= '0;
            rsp_prod <= '0;
            ops_done <= '0;
        end else begin
            if (w_grant) begin
                mul_a    <= w_sel_a;
                mul_b    <= w_sel_b;
                r_cur_id <= w_idx;
                r_last   <= w_idx;
            end
            if (r_state == c_CALC) begin
                rsp_prod <= mul_o;
                rsp_id   <= r_cur_id;
            end
            if ((r_state == c_RESP) && rsp_ready && (ops_done != c_OPS_MAX)) begin
                ops_done <= ops_done + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul8u_share_arb.sv
`default_nettype none
// ============================================================================
// tb_mul8u_share_arb : directed bench with response scoreboard
// Revision           : 1.0
// ============================================================================
module tb_mul8u_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_o;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_prod;
    logic        busy;
    logic [15:0] ops_done;

    int total = 0;
    int bad   = 0;

    int          m_st;
    logic [1:0]  m_last;
    logic [15:0] m_ops;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [17:0] sb[$];
    int          grants[4];

    always #5 clk = ~clk;

    // Exact multiplier stub standing in for the shared mul8u instance.
    assign mul_o = {8'd0, mul_a} * {8'd0, mul_b};

    mul8u_share_arb #(.N_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_prod(rsp_prod), .busy(busy), .ops_done(ops_done)
    );

    function automatic logic [3:0] arb(input logic [3:0] v, input logic [1:0] last);
        logic [3:0] g;
        int         i;
        g = 4'b0;
        for (int k = 1; k <= 4; k++) begin
            i = (int'(last) + k) % 4;
            if (g == 4'b0 && v[i]) g[i] = 1'b1;
        end
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, advance model, step past the edge.
    task automatic cyc();
        logic [3:0]  eg;
        logic        slot;
        logic [17:0] e;
        logic [15:0] p;
        #2;
        if (rst) begin
            chk("req_ready_in_rst", {28'd0, req_ready}, 32'd0);
        end else begin
            slot = (m_st == 0) || (m_st == 2 && rsp_ready);
            eg   = slot ? arb(req_valid, m_last) : 4'b0;
            chk("req_ready", {28'd0, req_ready}, {28'd0, eg});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, (m_st == 2)});
            chk("busy", {31'd0, busy}, {31'd0, (m_st != 0)});
            chk("ops_done", {16'd0, ops_done}, {16'd0, m_ops});
            if (m_st == 1) begin
                chk("mul_a", {24'd0, mul_a}, {24'd0, m_a});
                chk("mul_b", {24'd0, mul_b}, {24'd0, m_b});
            end
            if (m_st == 2) begin
                e = (sb.size() > 0) ? sb[0] : 18'h3FFFF;
                chk("rsp_id", {30'd0, rsp_id}, {30'd0, e[17:16]});
                chk("rsp_prod", {16'd0, rsp_prod}, {16'd0, e[15:0]});
                if (rsp_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    if (m_ops != 16'hFFFF) m_ops = m_ops + 16'd1;
                end
            end
            if (m_st == 1) m_st = 2;
            else if (m_st == 0 || rsp_ready) m_st = (eg != 4'b0) ? 1 : 0;
            for (int i = 0; i < 4; i++) begin
                if (eg[i]) begin
                    m_last = 2'(i);
                    m_a    = req_a[8*i +: 8];
                    m_b    = req_b[8*i +: 8];
                    p      = {8'd0, m_a} * {8'd0, m_b};
                    sb.push_back({2'(i), p});
                    grants[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_st = 0; m_last = 2'd3; m_ops = 16'd0; m_a = 8'd0; m_b = 8'd0;
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'b0; req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b0;
        m_st = 0; m_last = 2'd3; m_ops = 16'd0; m_a = 8'd0; m_b = 8'd0;
        for (int i = 0; i < 4; i++) grants[i] = 0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_mul_a", {24'd0, mul_a}, 32'd0);
        chk("rst_mul_b", {24'd0, mul_b}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_rsp_prod", {16'd0, rsp_prod}, 32'd0);
        chk("rst_ops_done", {16'd0, ops_done}, 32'd0);

        // Single request 12*13
        rsp_ready = 1'b1;
        req_valid = 4'b0001; req_a[7:0] = 8'd12; req_b[7:0] = 8'd13;
        cyc();
        req_valid = 4'b0000;
        cyc();
        chk("single_prod", {16'd0, rsp_prod}, 32'd156);
        cyc();
        cyc();
        chk("single_ops", {16'd0, ops_done}, 32'd1);

        // Fairness with all requesters pending
        req_a = 32'h0B_07_05_03; req_b = 32'h11_0D_FF_02;
        for (int i = 0; i < 4; i++) grants[i] = 0;
        req_valid = 4'b1111;
        for (int n = 0; n < 16; n++) cyc();
        for (int i = 0; i < 4; i++) chk("fair_grants", grants[i], 32'd2);
        req_valid = 4'b0000;
        cyc();
        cyc();

        // Backpressure: response held, no grants, then grant 2 at the handshake
        rsp_ready = 1'b0;
        req_valid = 4'b0010; req_a[15:8] = 8'd9; req_b[15:8] = 8'd21;
        cyc();
        req_valid = 4'b0110; req_a[15:8] = 8'd40; req_b[15:8] = 8'd3;
        req_a[23:16] = 8'd100; req_b[23:16] = 8'd77;
        cyc();
        for (int n = 0; n < 5; n++) cyc();
        chk("bp_prod_held", {16'd0, rsp_prod}, 32'd189);
        rsp_ready = 1'b1;
        #2;
        chk("bp_grant2", {28'd0, req_ready}, 32'd4);
        #0;
        cyc();
        req_valid = 4'b0010;
        cyc();
        cyc();
        req_valid = 4'b0000;
        cyc();
        cyc();
        cyc();

        // Operand extremes
        req_valid = 4'b0011;
        req_a[7:0] = 8'd255; req_b[7:0] = 8'd255;
        req_a[15:8] = 8'd0;  req_b[15:8] = 8'd200;
        cyc();
        req_valid = 4'b0010;
        cyc();
        chk("ext_max", {16'd0, rsp_prod}, 32'd65025);
        cyc();
        req_valid = 4'b0000;
        cyc();
        chk("ext_zero", {16'd0, rsp_prod}, 32'd0);
        cyc();
        cyc();

        // Reset during CALC drops the operation
        req_valid = 4'b0100; req_a[23:16] = 8'd50; req_b[23:16] = 8'd60;
        cyc();
        req_valid = 4'b0000;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("midrst_ops", {16'd0, ops_done}, 32'd0);
        req_valid = 4'b1111;
        req_a = 32'h04_03_02_01; req_b = 32'h08_07_06_05;
        cyc();
        req_valid = 4'b0000;
        cyc();
        cyc();
        cyc();

        // ops_done saturation
        m_ops = 16'hFFFE;
        force dut.ops_done = 16'hFFFE;
        cyc();
        release dut.ops_done;
        for (int r = 0; r < 2; r++) begin
            req_valid = 4'b0001;
            cyc();
            req_valid = 4'b0000;
            cyc();
            cyc();
            cyc();
            chk("sat_ops", {16'd0, ops_done}, 32'hFFFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
